// File: rtl/axi_write_interconnect.sv
// rtl/axi_write_interconnect.sv - round-robin AXI write-path interconnect, NUM_SLAVES sources to two targets
// One burst in flight at a time; each burst is routed to m1 when its address is >= M1_BASE_ADDRESS, else m0.
module axi_write_interconnect #(
  parameter int                    NUM_SLAVES      = 2,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] M1_BASE_ADDRESS = 32'hfffee000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_SLAVES-1:0]            s_awvalid,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_awaddr,
  input  logic [NUM_SLAVES*8-1:0]          s_awlen,
  output logic [NUM_SLAVES-1:0]            s_awready,
  input  logic [NUM_SLAVES-1:0]            s_wvalid,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_wdata,
  input  logic [NUM_SLAVES-1:0]            s_wlast,
  output logic [NUM_SLAVES-1:0]            s_wready,
  output logic [NUM_SLAVES-1:0]            s_bvalid,
  output logic [1:0]                       s_bresp,
  input  logic [NUM_SLAVES-1:0]            s_bready,
  output logic [1:0]                       m_awvalid,
  output logic [ADDR_WIDTH-1:0]            m_awaddr,
  output logic [7:0]                       m_awlen,
  input  logic [1:0]                       m_awready,
  output logic [1:0]                       m_wvalid,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic                             m_wlast,
  input  logic [1:0]                       m_wready,
  input  logic [1:0]                       m_bvalid,
  input  logic [3:0]                       m_bresp,
  output logic [1:0]                       m_bready,
  output logic                             burst_error
);

  localparam int GW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    ARBITRATE     = 2'd0,
    ISSUE_ADDRESS = 2'd1,
    ACTIVE_BURST  = 2'd2,
    WAIT_RESPONSE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [GW-1:0]         r_grant;
  logic [GW-1:0]         r_last_grant;
  logic                  r_target;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_count;
  logic                  r_burst_error;

  logic [ADDR_WIDTH-1:0] w_awaddr [NUM_SLAVES];
  logic [7:0]            w_awlen  [NUM_SLAVES];
  logic [DATA_WIDTH-1:0] w_wdata  [NUM_SLAVES];
  logic [GW-1:0]         w_idx;
  logic [GW-1:0]         w_pick;
  logic                  w_found;
  logic                  w_aw_hs;
  logic                  w_w_hs;

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_awaddr[i] = s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_awlen[i]  = s_awlen[i*8 +: 8];
      w_wdata[i]  = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan starts just past the last winner so every requester is served in turn.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_SLAVES; i++) begin
      w_idx = GW'((int'(r_last_grant) + i) % NUM_SLAVES);
      if (!w_found && s_awvalid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ARBITRATE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_aw_hs   = 1'b0;
    w_w_hs    = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = 2'b00;
    m_awvalid = 2'b00;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_wvalid  = 2'b00;
    m_wdata   = '0;
    m_wlast   = 1'b0;
    m_bready  = 2'b00;
    case (r_state)
      ARBITRATE: begin
        if (w_found) w_next = ISSUE_ADDRESS;
      end
      ISSUE_ADDRESS: begin
        m_awvalid[r_target] = 1'b1;
        m_awaddr            = r_addr;
        m_awlen             = r_len;
        s_awready[r_grant]  = m_awready[r_target];
        w_aw_hs             = m_awready[r_target];
        if (w_aw_hs) w_next = ACTIVE_BURST;
      end
      ACTIVE_BURST: begin
        m_wvalid[r_target] = s_wvalid[r_grant];
        s_wready[r_grant]  = m_wready[r_target];
        m_wdata            = w_wdata[r_grant];
        m_wlast            = (r_count == 8'd0);
        w_w_hs             = s_wvalid[r_grant] & m_wready[r_target];
        if (w_w_hs && r_count == 8'd0) w_next = WAIT_RESPONSE;
      end
      WAIT_RESPONSE: begin
        s_bvalid[r_grant]  = m_bvalid[r_target];
        m_bready[r_target] = s_bready[r_grant];
        s_bresp            = r_target ? m_bresp[3:2] : m_bresp[1:0];
        if (m_bvalid[r_target] && s_bready[r_grant]) w_next = ARBITRATE;
      end
      default: w_next = ARBITRATE;
    endcase
  end

  // Source wlast is only compared, never used: awlen alone decides the burst length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant       <= '0;
      r_last_grant  <= GW'(NUM_SLAVES - 1);
      r_target      <= 1'b0;
      r_addr        <= '0;
      r_len         <= '0;
      r_count       <= '0;
      r_burst_error <= 1'b0;
    end else begin
      r_burst_error <= w_w_hs && (s_wlast[r_grant] != (r_count == 8'd0));
      if (r_state == ARBITRATE && w_found) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        r_addr       <= w_awaddr[w_pick];
        r_len        <= w_awlen[w_pick];
        r_target     <= (w_awaddr[w_pick] >= M1_BASE_ADDRESS);
      end
      if (w_aw_hs) r_count <= r_len;
      else if (w_w_hs && r_count != 8'd0) r_count <= r_count - 8'd1;
    end
  end

  assign burst_error = r_burst_error;

endmodule

// File: tb/tb_axi_write_interconnect.sv
// tb/tb_axi_write_interconnect.sv - randomized self-checking bench for axi_write_interconnect
`timescale 1ns/1ps
module tb_axi_write_interconnect;

  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] BASE = 32'hfffee000;

  logic clk;
  logic reset;
  logic [NS-1:0]    s_awvalid;
  logic [NS*AW-1:0] s_awaddr;
  logic [NS*8-1:0]  s_awlen;
  logic [NS-1:0]    s_awready;
  logic [NS-1:0]    s_wvalid;
  logic [NS*DW-1:0] s_wdata;
  logic [NS-1:0]    s_wlast;
  logic [NS-1:0]    s_wready;
  logic [NS-1:0]    s_bvalid;
  logic [1:0]       s_bresp;
  logic [NS-1:0]    s_bready;
  logic [1:0]       m_awvalid;
  logic [AW-1:0]    m_awaddr;
  logic [7:0]       m_awlen;
  logic [1:0]       m_awready;
  logic [1:0]       m_wvalid;
  logic [DW-1:0]    m_wdata;
  logic             m_wlast;
  logic [1:0]       m_wready;
  logic [1:0]       m_bvalid;
  logic [3:0]       m_bresp;
  logic [1:0]       m_bready;
  logic             burst_error;

  axi_write_interconnect #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .M1_BASE_ADDRESS(BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .burst_error(burst_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          bad;
  } burst_t;

  burst_t     bq[NS][$];
  logic [1:0] rsp_q[2][$];
  int         exp_order[$];
  int         ph[NS];
  int         bi[NS];
  int         bt[NS];
  int         err_exp;
  int         err_seen;
  int         beats_seen;
  int         checks = 0;
  int         failures = 0;

  function automatic logic [31:0] beat_data(input int p, input int k, input int b);
    return (32'(p) * 32'h01000193) ^ (32'(k) << 20) ^ 32'(b) ^ 32'ha5a50000;
  endfunction

  task automatic drive_idle();
    s_awvalid = '0; s_awaddr = '0; s_awlen = '0;
    s_wvalid = '0; s_wdata = '0; s_wlast = '0; s_bready = '0;
    m_awready = 2'b00; m_wready = 2'b00; m_bvalid = 2'b00; m_bresp = 4'h0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic clear_bursts();
    for (int p = 0; p < NS; p++) bq[p].delete();
  endtask

  task automatic add_burst(input int p, input logic [31:0] a, input logic [7:0] l, input int bad);
    burst_t b;
    b.addr = a; b.len = l; b.bad = bad;
    bq[p].push_back(b);
  endtask

  task automatic run_engine(input int mode, input int strayen, input int abort_after, input int budget);
    int rem[NS];
    int last, placed, total, tx, cyc, ep, et, wcyc, pe, q;
    burst_t cb;
    logic [NS-1:0] oth;
    total = 0;
    for (int p = 0; p < NS; p++) begin
      rem[p] = bq[p].size(); total += rem[p];
      ph[p] = 0; bi[p] = 0; bt[p] = 0;
    end
    exp_order.delete();
    last = NS - 1; placed = 0;
    while (placed < total) begin
      for (int i = 1; i <= NS; i++) begin
        q = (last + i) % NS;
        if (rem[q] > 0) begin
          exp_order.push_back(q); rem[q]--; last = q; placed++;
          break;
        end
      end
    end
    rsp_q[0].delete(); rsp_q[1].delete();
    err_exp = 0; err_seen = 0; beats_seen = 0; tx = 0; cyc = 0; wcyc = 0;
    while (tx < total && cyc < budget && !(abort_after > 0 && beats_seen >= abort_after)) begin
      @(posedge clk); #1;
      for (int p = 0; p < NS; p++) begin
        if (bi[p] < bq[p].size()) begin
          cb = bq[p][bi[p]];
          s_awvalid[p] = (ph[p] == 0);
          s_awaddr[p*AW +: AW] = cb.addr;
          s_awlen[p*8 +: 8] = cb.len;
          s_wvalid[p] = (ph[p] == 1) && (mode != 0 || $urandom_range(0, 3) != 0);
          s_wdata[p*DW +: DW] = beat_data(p, bi[p], bt[p]);
          s_wlast[p] = (ph[p] == 1) && ((bt[p] == int'(cb.len)) != (bt[p] == cb.bad));
          s_bready[p] = (ph[p] == 2) && (mode != 0 || $urandom_range(0, 2) != 0);
        end else begin
          s_awvalid[p] = 1'b0; s_awaddr[p*AW +: AW] = '0; s_awlen[p*8 +: 8] = '0;
          s_wvalid[p] = 1'b0; s_wdata[p*DW +: DW] = '0; s_wlast[p] = 1'b0; s_bready[p] = 1'b0;
        end
      end
      m_awready = (mode == 0) ? 2'($urandom) : 2'b11;
      if (mode == 0)      m_wready = 2'($urandom);
      else if (mode == 1) m_wready = (wcyc % 4 == 0 || wcyc % 4 == 3) ? 2'b11 : 2'b00;
      else                m_wready = 2'b11;
      for (int t = 0; t < 2; t++) begin
        if (rsp_q[t].size() > 0) begin
          m_bvalid[t] = 1'b1; m_bresp[2*t +: 2] = rsp_q[t][0];
        end else if (strayen != 0 && $urandom_range(0, 3) == 0) begin
          m_bvalid[t] = 1'b1; m_bresp[2*t +: 2] = 2'b11;
        end else begin
          m_bvalid[t] = 1'b0; m_bresp[2*t +: 2] = 2'b00;
        end
      end
      @(negedge clk);
      ep = exp_order[tx];
      cb = bq[ep][bi[ep]];
      et = (cb.addr >= BASE) ? 1 : 0;
      pe = ph[ep];
      oth = '1; oth[ep] = 1'b0;
      if (burst_error === 1'b1) err_seen++;
      checks++;
      if (((s_awready | s_wready | s_bvalid) & oth) !== '0) begin
        failures++;
        $display("FAIL isolation: got aw=%b w=%b b=%b, only port %0d may be active", s_awready, s_wready, s_bvalid, ep);
      end
      checks++;
      if ({m_awvalid[1-et], m_wvalid[1-et], m_bready[1-et]} !== 3'b000) begin
        failures++;
        $display("FAIL non_target: target %0d got awv=%b wv=%b br=%b, required 0", 1-et, m_awvalid[1-et], m_wvalid[1-et], m_bready[1-et]);
      end
      checks++;
      if (s_awready[ep] !== (m_awvalid[et] & m_awready[et])) begin
        failures++;
        $display("FAIL awready_fwd: got %b required %b", s_awready[ep], m_awvalid[et] & m_awready[et]);
      end
      if (pe != 0) begin
        checks++;
        if (m_awvalid[et] !== 1'b0) begin
          failures++;
          $display("FAIL aw_phase: got m_awvalid=%b required 0", m_awvalid[et]);
        end
      end else if (m_awvalid[et] === 1'b1) begin
        checks++;
        if ({m_awaddr, m_awlen} !== {cb.addr, cb.len}) begin
          failures++;
          $display("FAIL aw_fields: got %h/%0d required %h/%0d", m_awaddr, m_awlen, cb.addr, cb.len);
        end
        if (s_awvalid[ep] && s_awready[ep]) begin ph[ep] = 1; bt[ep] = 0; end
      end
      if (pe == 1) begin
        wcyc++;
        checks++;
        if ({s_wready[ep], m_wvalid[et]} !== {m_wready[et], s_wvalid[ep]}) begin
          failures++;
          $display("FAIL w_fwd: got wready/wvalid=%b%b required %b%b", s_wready[ep], m_wvalid[et], m_wready[et], s_wvalid[ep]);
        end
        if (s_wvalid[ep] && s_wready[ep]) begin
          checks++;
          if ({m_wdata, m_wlast} !== {beat_data(ep, bi[ep], bt[ep]), bt[ep] == int'(cb.len)}) begin
            failures++;
            $display("FAIL w_beat: port %0d beat %0d got %h last=%b required %h last=%b", ep, bt[ep],
                     m_wdata, m_wlast, beat_data(ep, bi[ep], bt[ep]), bt[ep] == int'(cb.len));
          end
          if (bt[ep] == cb.bad) err_exp++;
          beats_seen++;
          bt[ep]++;
          if (bt[ep] > int'(cb.len)) begin
            ph[ep] = 2;
            rsp_q[et].push_back(2'($urandom));
          end
        end
      end else begin
        checks++;
        if ({s_wready[ep], m_wvalid[et]} !== 2'b00) begin
          failures++;
          $display("FAIL w_phase: got wready/wvalid=%b%b required 00", s_wready[ep], m_wvalid[et]);
        end
      end
      if (pe == 2) begin
        checks++;
        if ({s_bvalid[ep], m_bready[et]} !== {m_bvalid[et], s_bready[ep]}) begin
          failures++;
          $display("FAIL b_fwd: got bvalid/bready=%b%b required %b%b", s_bvalid[ep], m_bready[et], m_bvalid[et], s_bready[ep]);
        end
        if (s_bvalid[ep] === 1'b1) begin
          checks++;
          if (s_bresp !== rsp_q[et][0]) begin
            failures++;
            $display("FAIL b_resp: got %b required %b", s_bresp, rsp_q[et][0]);
          end
        end
        if (m_bvalid[et] && s_bready[ep]) begin
          void'(rsp_q[et].pop_front());
          ph[ep] = 0; bt[ep] = 0; bi[ep]++; tx++;
        end
      end else begin
        checks++;
        if ({s_bvalid[ep], m_bready[et]} !== 2'b00) begin
          failures++;
          $display("FAIL b_phase: got bvalid/bready=%b%b required 00", s_bvalid[ep], m_bready[et]);
        end
      end
      cyc++;
    end
    if (abort_after == 0) begin
      checks++;
      if (tx != total) begin
        failures++;
        $display("FAIL complete: got %0d transactions required %0d (cycle budget %0d)", tx, total, budget);
      end
      checks++;
      if (err_seen != err_exp) begin
        failures++;
        $display("FAIL burst_error_count: got %0d pulses required %0d", err_seen, err_exp);
      end
    end
  endtask

  task automatic test_reset();
    s_awvalid = '1; s_wvalid = '1; s_bready = '1; s_wlast = '1;
    m_awready = 2'b11; m_wready = 2'b11; m_bvalid = 2'b11; m_bresp = 4'hf;
    reset = 1'b1;
    #1;
    checks++;
    if ({s_awready, s_wready, s_bvalid, m_awvalid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready, burst_error} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got aw=%b w=%b b=%b mav=%b maddr=%h mwv=%b mbr=%b err=%b, required all 0",
               s_awready, s_wready, s_bvalid, m_awvalid, m_awaddr, m_wvalid, m_bready, burst_error);
    end
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    @(posedge clk); #1;
    s_awvalid[0] = 1'b1; s_awaddr[0 +: AW] = 32'h1000; s_awlen[0 +: 8] = 8'd3;
    @(negedge clk);
    checks++;
    if (m_awvalid !== 2'b00) begin
      failures++;
      $display("FAIL latency_early: got m_awvalid=%b required 00", m_awvalid);
    end
    @(negedge clk);
    checks++;
    if ({m_awvalid, m_awaddr, m_awlen} !== {2'b01, 32'h1000, 8'd3}) begin
      failures++;
      $display("FAIL latency_issue: got %b %h %0d required 01 00001000 3", m_awvalid, m_awaddr, m_awlen);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset(); clear_bursts();
    add_burst(0, 32'h1000, 8'd3, -1);
    run_engine(2, 0, 0, 200);
  endtask

  task automatic test_routing();
    do_reset(); clear_bursts();
    add_burst(1, BASE, 8'd0, -1);
    add_burst(1, BASE - 32'd4, 8'd0, -1);
    run_engine(2, 0, 0, 200);
  endtask

  task automatic test_round_robin();
    do_reset(); clear_bursts();
    add_burst(0, 32'h100, 8'd1, -1); add_burst(0, BASE + 32'h10, 8'd2, -1);
    add_burst(1, BASE, 8'd0, -1);    add_burst(1, 32'h200, 8'd1, -1);
    run_engine(2, 0, 0, 400);
  endtask

  task automatic test_wready_pattern();
    do_reset(); clear_bursts();
    add_burst(0, 32'h2000, 8'd1, -1);
    run_engine(1, 0, 0, 200);
    checks++;
    if (beats_seen != 2) begin
      failures++;
      $display("FAIL wready_beats: got %0d beats required 2", beats_seen);
    end
  endtask

  task automatic test_wlast_error();
    do_reset(); clear_bursts();
    add_burst(0, 32'h3000, 8'd2, 0);
    run_engine(2, 0, 0, 200);
    checks++;
    if (beats_seen != 3 || err_seen != 1) begin
      failures++;
      $display("FAIL wlast_error: got %0d beats %0d pulses required 3 beats 1 pulse", beats_seen, err_seen);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset(); clear_bursts();
    add_burst(0, 32'h4000, 8'd3, -1);
    run_engine(2, 0, 1, 100);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready, m_wdata, m_wlast} !== '0) begin
      failures++;
      $display("FAIL reset_mid_burst: got sw=%b mwv=%b mwdata=%h mwlast=%b required all 0", s_wready, m_wvalid, m_wdata, m_wlast);
    end
    drive_idle();
    @(posedge clk); #1 reset = 1'b0;
    clear_bursts();
    add_burst(1, 32'h5000, 8'd2, -1);
    add_burst(0, BASE + 32'h40, 8'd1, -1);
    run_engine(0, 1, 0, 2000);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0]  l;
    int          n;
    do_reset(); clear_bursts();
    for (int p = 0; p < NS; p++) begin
      n = $urandom_range(2, 4);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0:       a = $urandom_range(0, 32'h7fffffff) & 32'hfffffffc;
          1:       a = BASE + (32'($urandom_range(0, 255)) << 2);
          2:       a = BASE - 32'd4;
          default: a = BASE;
        endcase
        l = (p == 2 && k == 0) ? 8'd255 : 8'($urandom_range(0, 7));
        add_burst(p, a, l, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l))) : -1);
      end
    end
    run_engine(0, 1, 0, 20000);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_latency();
    test_basic();
    test_routing();
    test_round_robin();
    test_wready_pattern();
    test_wlast_error();
    test_reset_mid_burst();
    test_random();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
